sum_stream_buffer: RTL and testbench
====================================

Name: sum_stream_buffer

Overview:
Downstream consumer of the 8-bit operand-sum produced by the adder stage in the top-level tile. Buffers the sum stream in a small FIFO with valid/ready handshakes on both sides, so a slow consumer can stall without losing samples. Keeps a saturating running total of every sum that leaves the buffer. Provides a synchronous flush that clears the pipeline.

Parameters:
DATA_W, 8, width of each sum word (matches adder output)
DEPTH, 4, FIFO entries; power of two, >= 2
ACC_W, 16, running-total width; ACC_W > DATA_W

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_W  sum word from adder stage
in_valid  input  1  in_data valid
in_ready  output  1  buffer can accept a word this cycle
flush  input  1  synchronous clear of FIFO, total and flag
out_data  output  DATA_W  head-of-FIFO word
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data this cycle
out_acc  output  ACC_W  saturating sum of all popped words since reset/flush
sat  output  1  sticky: out_acc has saturated
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n low, async): read/write pointers, count, out_acc and sat all go to 0. out_valid=0, in_ready=1. Memory contents are don't-care. out_data is don't-care while out_valid=0.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count < DEPTH). It depends only on registered state, never on out_ready. When the FIFO is full, a same-cycle pop does not open a slot for a push.
- out_valid = (count != 0).
- out_data = mem[rd_ptr]. First-word-fall-through from registered storage.
- Latency: a word pushed at edge N into an empty FIFO is presented with out_valid=1 in the cycle after edge N. There is no combinational in->out path.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, with order preserved.
- Order: strict FIFO, no reordering and no duplication.
- in_valid with in_ready=0: the word is not stored. Upstream must hold it (standard valid/ready; upstream must not drop valid without a transfer).
- Accumulator, on a pop: out_acc <= min(out_acc + out_data, 2^ACC_W-1), zero-extended add.
  - If the unsaturated sum exceeds 2^ACC_W-1, sat <= 1.
  - Reaching exactly 2^ACC_W-1 does not set sat.
- Once set, sat stays 1 and out_acc stays at max until reset or flush.
- out_acc and sat update at the same edge as the pop. The new value is visible the following cycle.
- flush (synchronous, highest priority): pointers, count, out_acc and sat all go to 0 at the next edge.
  - Any push or pop in the same cycle is discarded: no store, and no accumulation of the popped word.
  - in_ready and out_valid follow the new count (1 and 0) from the next cycle.
- Reset asserted mid-transfer: state clears immediately and asynchronously. Words in flight are lost. Deassertion is assumed synchronised upstream of the block.

Test Plan:
- Reset -> out_valid=0, in_ready=1, count=0, out_acc=0, sat=0. Check during and after rst_n low.
- Push 0x2A into empty FIFO with out_ready=0 -> next cycle out_valid=1, out_data=0x2A, count=1. Hold 3 cycles: data stable, out_acc=0.
- Push 0x01..0x05 with out_ready=0 -> 0x01..0x04 accepted, count=4, in_ready=0, 0x05 held by source. Pop once with in_valid still high -> count=3 that cycle, 0x05 accepted the next cycle. Drain order is 01,02,03,04,05 and out_acc ends at 0x000F.
- Steady streaming at count=2 with in_valid=out_ready=1 for 10 cycles, incrementing data -> count stays 2, output sequence exactly matches the input sequence, out_acc equals the sum of popped words.
- Pop 0xFF 257 times -> out_acc=0xFFFF, sat=0. 258th pop of 0xFF -> out_acc=0xFFFF, sat=1. A following pop of 0x01 leaves both unchanged.
- flush with count=3 and push+pop asserted the same cycle -> next cycle count=0, out_valid=0, in_ready=1, out_acc=0, sat=0. The popped word is not accumulated and the pushed word is absent.

Source files
------------

// File: rtl/sum_stream_buffer_if.sv
// Handshake and status bundle for the sum stream buffer.
// slave: the buffer itself; master: the adder stage / consumer side driving it.
interface sum_stream_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              sat;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, out_acc, sat, count
    );

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, out_acc, sat, count
    );
endinterface

// File: rtl/sum_stream_buffer.sv
// Sum stream buffer: small FWFT FIFO between the adder stage and a possibly
// slow consumer, with a saturating running total of every word that leaves
// and a synchronous flush that clears storage state, total and sticky flag.
module sum_stream_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sum_stream_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;

    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [ACC_W:0]    acc_sum;

    // in_ready looks only at registered occupancy, so a full FIFO never
    // takes a word even if the consumer pops in the same cycle.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;
    assign head      = mem_q[rd_ptr_q];

    // One extra bit catches overflow of the zero-extended add.
    assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, head};

    // Next-state for pointers, occupancy, running total and sticky flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            acc_d    = '0;
            sat_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (acc_sum[ACC_W]) begin
                    acc_d = ACC_MAX;
                    sat_d = 1'b1;
                end else begin
                    acc_d = acc_sum[ACC_W-1:0];
                end
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
        end
    end

    // Storage needs no reset; contents are only read while count is nonzero.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head;
    assign bus.out_acc   = acc_q;
    assign bus.sat       = sat_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_sum_stream_buffer.sv
// Directed plus randomized bench for sum_stream_buffer against a queue-based
// reference model of the buffer, running total and sticky saturation flag.
module tb_sum_stream_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ACC_W  = 16;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sum_stream_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W)) bus ();

    sum_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    byte unsigned mq[$];
    int unsigned  m_acc = 0;
    bit           m_sat = 1'b0;
    bit           m_pushed;
    bit           m_popped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_acc = 0;
        m_sat = 1'b0;
    endtask

    task automatic model_edge();
        int unsigned t;
        bit room;
        m_pushed = 1'b0;
        m_popped = 1'b0;
        if (!rst_n || bus.flush) begin
            model_clear();
            return;
        end
        room = (mq.size() < DEPTH);
        if (mq.size() != 0 && bus.out_ready) begin
            t = m_acc + int'(mq.pop_front());
            if (t > ACC_MAX) begin
                m_acc = ACC_MAX;
                m_sat = 1'b1;
            end else begin
                m_acc = t;
            end
            m_popped = 1'b1;
        end
        if (bus.in_valid && room) begin
            mq.push_back(bus.in_data);
            m_pushed = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("count", 32'(bus.count), mq.size());
        chk("out_valid", 32'(bus.out_valid), (mq.size() != 0) ? 1 : 0);
        chk("in_ready", 32'(bus.in_ready), (mq.size() < DEPTH) ? 1 : 0);
        chk("out_acc", 32'(bus.out_acc), m_acc);
        chk("sat", 32'(bus.sat), 32'(m_sat));
        if (mq.size() != 0) chk("out_data", 32'(bus.out_data), 32'(mq[0]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        // reset
        rst_n = 1'b0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_acc", 32'(bus.out_acc), 0);
        chk("rst_sat", 32'(bus.sat), 0);
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;
        cycle();

        // single word, held without pop
        bus.in_valid = 1'b1;
        bus.in_data = 8'h2A;
        cycle();
        bus.in_valid = 1'b0;
        chk("2a_valid", 32'(bus.out_valid), 1);
        chk("2a_count", 32'(bus.count), 1);
        repeat (3) begin
            cycle();
            chk("2a_data", 32'(bus.out_data), 32'h2A);
            chk("2a_acc", 32'(bus.out_acc), 0);
        end
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;

        // fill to full, held word, single pop, drain
        v = 1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'(v);
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (m_pushed) v++;
            bus.in_data = 8'(v);
        end
        chk("full_count", 32'(bus.count), 4);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_head", 32'(bus.out_data), 1);
        bus.out_ready = 1'b1;
        cycle();
        chk("full_pop_count", 32'(bus.count), 3);
        bus.out_ready = 1'b0;
        cycle();
        chk("held_accept_count", 32'(bus.count), 4);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("drain_order", 32'(bus.out_data), i);
            cycle();
        end
        chk("drain_acc", 32'(bus.out_acc), 32'h000F);
        chk("drain_count", 32'(bus.count), 0);

        // steady streaming at occupancy 2
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h10;
        cycle();
        bus.in_data = 8'h11;
        cycle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 8'(8'h12 + i);
            cycle();
            chk("stream_count", 32'(bus.count), 2);
        end
        bus.in_valid = 1'b0;
        cycle();
        cycle();

        // randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_data = 8'($urandom);
            bus.flush = ($urandom_range(0, 31) == 0);
            cycle();
        end
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;

        // saturation boundary
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        for (int w = 0; w < 259; w++) begin
            bus.in_data = (w < 258) ? 8'hFF : 8'h01;
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b0;
            cycle();
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            cycle();
            bus.out_ready = 1'b0;
            if (w == 256) begin
                chk("sat257_acc", 32'(bus.out_acc), 32'hFFFF);
                chk("sat257_flag", 32'(bus.sat), 0);
            end
            if (w >= 257) begin
                chk("sat_acc", 32'(bus.out_acc), 32'hFFFF);
                chk("sat_flag", 32'(bus.sat), 1);
            end
        end

        // flush with push and pop in the same cycle
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'(8'h40 + i);
            cycle();
        end
        chk("preflush_count", 32'(bus.count), 3);
        bus.flush = 1'b1;
        bus.in_data = 8'h77;
        bus.out_ready = 1'b1;
        cycle();
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_out_valid", 32'(bus.out_valid), 0);
        chk("flush_in_ready", 32'(bus.in_ready), 1);
        chk("flush_acc", 32'(bus.out_acc), 0);
        chk("flush_sat", 32'(bus.sat), 0);
        bus.in_data = 8'h33;
        cycle();
        bus.in_valid = 1'b0;
        chk("postflush_head", 32'(bus.out_data), 32'h33);
        chk("postflush_count", 32'(bus.count), 1);

        // asynchronous reset in the middle of streaming
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data = 8'h5A;
        cycle();
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("async_rst_count", 32'(bus.count), 0);
        chk("async_rst_acc", 32'(bus.out_acc), 0);
        check_model();
        cycle();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
